shared_mem_arbiter: RTL and testbench

Parametrised single-port unified memory with a two-master arbiter: an instruction-fetch port and a data load/store port share one RAM array through a valid/ready handshake. It sits between the cpu and the memory system and replaces separate instruction and data memories. It adds configurable width, depth and wait states, byte-lane writes, and fair arbitration. Both request ports are multi-cycle.

---
 rtl/shared_mem_if.sv | 34 +++
 rtl/shared_mem_arbiter.sv | 133 +++++++++++++
 tb/tb_shared_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/shared_mem_if.sv
// shared_mem_if: request/response bundle between the cpu and the shared memory.
//   Fetch side:  i_valid, i_addr (to memory), i_ready, i_rdata (from memory)
//   Data side:   d_valid, d_we, d_be, d_addr, d_wdata (to memory),
//                d_ready, d_rdata (from memory)
//   Status:      busy (from memory), high while a transaction is in flight
//   master modport = cpu side, slave modport = memory side.
interface shared_mem_if #(
  parameter int XLEN = 32
);
  logic              i_valid;
  logic [XLEN-1:0]   i_addr;
  logic              i_ready;
  logic [XLEN-1:0]   i_rdata;

  logic              d_valid;
  logic              d_we;
  logic [XLEN/8-1:0] d_be;
  logic [XLEN-1:0]   d_addr;
  logic [XLEN-1:0]   d_wdata;
  logic              d_ready;
  logic [XLEN-1:0]   d_rdata;

  logic              busy;

  modport master (
    output i_valid, i_addr, d_valid, d_we, d_be, d_addr, d_wdata,
    input  i_ready, i_rdata, d_ready, d_rdata, busy
  );

  modport slave (
    input  i_valid, i_addr, d_valid, d_we, d_be, d_addr, d_wdata,
    output i_ready, i_rdata, d_ready, d_rdata, busy
  );
endinterface

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: single-port unified memory shared by an instruction
// fetch port and a data load/store port, with alternating-priority arbitration
// and a configurable number of wait states per access.
//   clk    rising-edge clock
//   reset  asynchronous active-high reset
//   bus    shared_mem_if slave modport (fetch port, data port, busy)
//
//   state  | meaning
//   IDLE   | arbitrate; grant on any valid request and latch it
//   ACCESS | count WAIT+1 cycles; the cnt==0 edge commits to the array
//   RESP   | one-cycle ready pulse on the granted port
module shared_mem_arbiter #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 1024,
  parameter int WAIT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  shared_mem_if.slave bus
);
  localparam int LANES = XLEN / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT4 = 4'(WAIT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state;
  logic [3:0]       cnt;
  logic             last_gnt;   // 1 = data port won the last grant
  logic             sel_d;
  logic             we_q;
  logic [LANES-1:0] be_q;
  logic [IDXW-1:0]  idx_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  rdata_q;
  logic             i_ready_q;
  logic             d_ready_q;
  logic             busy_q;

  logic [XLEN-1:0]  mem [DEPTH];

  logic             req_any;
  logic             pick_d;
  logic             commit;
  logic [IDXW-1:0]  i_idx;
  logic [IDXW-1:0]  d_idx;

  // Byte-offset bits and bits above the index are ignored; upper bits wrap.
  assign i_idx = bus.i_addr[OFFW +: IDXW];
  assign d_idx = bus.d_addr[OFFW +: IDXW];
  wire unused_addr_bits = ^{bus.i_addr, bus.d_addr};

  assign req_any = bus.i_valid | bus.d_valid;
  // On a tie the port that did not win last time gets the grant.
  assign pick_d  = bus.d_valid & (~bus.i_valid | ~last_gnt);
  assign commit  = (state == ACCESS) && (cnt == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      last_gnt  <= 1'b0;
      sel_d     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            state    <= ACCESS;
            busy_q   <= 1'b1;
            cnt      <= WAIT4;
            sel_d    <= pick_d;
            last_gnt <= pick_d;
            // The fetch port is read-only, so its grant never writes.
            we_q     <= pick_d & bus.d_we;
            be_q     <= bus.d_be;
            idx_q    <= pick_d ? d_idx : i_idx;
            wdata_q  <= bus.d_wdata;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            state <= RESP;
            if (!we_q) begin
              rdata_q <= mem[idx_q];
            end
            i_ready_q <= ~sel_d;
            d_ready_q <= sel_d;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Array write on the commit edge. An async reset forces IDLE first, so a
  // transaction interrupted before its commit edge never reaches the array.
  always_ff @(posedge clk) begin
    if (commit && we_q) begin
      for (int k = 0; k < LANES; k++) begin
        if (be_q[k]) begin
          mem[idx_q][8*k +: 8] <= wdata_q[8*k +: 8];
        end
      end
    end
  end

  assign bus.i_ready = i_ready_q;
  assign bus.d_ready = d_ready_q;
  assign bus.i_rdata = rdata_q;
  assign bus.d_rdata = rdata_q;
  assign bus.busy    = busy_q;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: scoreboard bench for shared_mem_arbiter. A WAIT=1
// instance carries the functional tests; WAIT=0 and WAIT=15 instances check
// latency at the wait-state extremes.
module tb_shared_mem_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic rst_x;

  always #5 clk = ~clk;

  shared_mem_if #(.XLEN(32)) m();
  shared_mem_if #(.XLEN(32)) b0();
  shared_mem_if #(.XLEN(32)) b15();

  shared_mem_arbiter #(.XLEN(32), .DEPTH(1024), .WAIT(1))  dut   (.clk(clk), .reset(rst),   .bus(m));
  shared_mem_arbiter #(.XLEN(32), .DEPTH(1024), .WAIT(0))  dut0  (.clk(clk), .reset(rst_x), .bus(b0));
  shared_mem_arbiter #(.XLEN(32), .DEPTH(1024), .WAIT(15)) dut15 (.clk(clk), .reset(rst_x), .bus(b15));

  typedef struct {
    bit          port_d;
    bit          chk_data;
    logic [31:0] data;
    string       name;
  } exp_t;

  exp_t sbq[$];
  exp_t exp_cur;
  int   n_pass;
  int   n_total;
  logic prev_rdy;
  logic prev0;
  logic prev15;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, req);
  endtask

  task automatic push(input string nm, input bit port_d, input bit chk_data, input logic [31:0] data);
    exp_t e;
    e.port_d   = port_d;
    e.chk_data = chk_data;
    e.data     = data;
    e.name     = nm;
    sbq.push_back(e);
  endtask

  // One isolated transaction on the WAIT=1 instance: expected response goes to
  // the scoreboard, latency and busy length are checked here.
  task automatic txn(input string nm, input bit port_d, input bit we, input logic [3:0] be,
                     input logic [31:0] addr, input logic [31:0] wdata, input logic [31:0] expd);
    int g;
    int lat;
    int nb;
    g = 0;
    @(negedge clk);
    while (m.busy && g < 50) begin @(negedge clk); g++; end
    push(nm, port_d, !we, expd);
    if (port_d) begin
      m.d_valid = 1'b1; m.d_we = we; m.d_be = be; m.d_addr = addr; m.d_wdata = wdata;
    end else begin
      m.i_valid = 1'b1; m.i_addr = addr;
    end
    lat = 0;
    nb  = 0;
    do begin
      @(negedge clk);
      lat++;
      if (m.busy) nb++;
    end while (!(m.i_ready || m.d_ready) && lat < 40);
    m.i_valid = 1'b0;
    m.d_valid = 1'b0;
    chk({nm, "_lat"}, lat, 3);
    chk({nm, "_busy"}, nb, 3);
    @(negedge clk);
    chk({nm, "_idle"}, 32'(m.busy), 0);
  endtask

  // Scoreboard monitor for the WAIT=1 instance.
  always @(negedge clk) begin
    if (!rst && (m.i_ready || m.d_ready)) begin
      chk("one_port_ready", 32'(m.i_ready & m.d_ready), 0);
      chk("ready_pulse", 32'(prev_rdy), 0);
      if (sbq.size() == 0) begin
        chk("sb_unexpected_ready", 1, 0);
      end else begin
        exp_cur = sbq.pop_front();
        chk({exp_cur.name, "_port"}, 32'(m.d_ready), 32'(exp_cur.port_d));
        if (exp_cur.chk_data)
          chk({exp_cur.name, "_data"}, exp_cur.port_d ? m.d_rdata : m.i_rdata, exp_cur.data);
      end
    end
    prev_rdy <= m.i_ready | m.d_ready;
  end

  always @(negedge clk) begin
    if (!rst_x && b0.d_ready)  chk("w0_pulse", 32'(prev0), 0);
    if (!rst_x && b15.d_ready) chk("w15_pulse", 32'(prev15), 0);
    prev0  <= b0.d_ready;
    prev15 <= b15.d_ready;
  end

  initial begin
    int g;
    int cnt;
    int bad;
    int lat;
    n_pass = 0; n_total = 0;
    prev_rdy = 1'b0; prev0 = 1'b0; prev15 = 1'b0;
    m.i_valid = 0; m.i_addr = 0; m.d_valid = 0; m.d_we = 0; m.d_be = 0; m.d_addr = 0; m.d_wdata = 0;
    b0.i_valid = 0; b0.i_addr = 0; b0.d_valid = 0; b0.d_we = 0; b0.d_be = 0; b0.d_addr = 0; b0.d_wdata = 0;
    b15.i_valid = 0; b15.i_addr = 0; b15.d_valid = 0; b15.d_we = 0; b15.d_be = 0; b15.d_addr = 0; b15.d_wdata = 0;
    rst = 1'b1;
    rst_x = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy",    32'(m.busy), 0);
    chk("rst_i_ready", 32'(m.i_ready), 0);
    chk("rst_d_ready", 32'(m.d_ready), 0);
    chk("rst_rdata",   m.i_rdata, 0);
    rst = 1'b0;
    rst_x = 1'b0;

    txn("st10",     1, 1, 4'hF,    32'h10,   32'hDEADBEEF, 0);
    txn("fetch10",  0, 0, 4'h0,    32'h10,   0,            32'hDEADBEEF);
    txn("st20",     1, 1, 4'hF,    32'h20,   32'h11223344, 0);
    txn("st20_be",  1, 1, 4'b0101, 32'h20,   32'hAABBCCDD, 0);
    txn("ld20",     1, 0, 4'h0,    32'h20,   0,            32'h11BB33DD);
    txn("st_be0",   1, 1, 4'h0,    32'h20,   32'hFFFFFFFF, 0);
    txn("ld20_b",   1, 0, 4'h0,    32'h20,   0,            32'h11BB33DD);
    txn("st_wrap",  1, 1, 4'hF,    32'h1000, 32'h5A5A5A5A, 0);
    txn("ld_wrap0", 1, 0, 4'h0,    32'h0,    0,            32'h5A5A5A5A);
    txn("ld_wrap3", 1, 0, 4'h0,    32'h1003, 0,            32'h5A5A5A5A);
    txn("if_wrap3", 0, 0, 4'h0,    32'h1003, 0,            32'h5A5A5A5A);
    txn("st40_0",   1, 1, 4'hF,    32'h40,   32'h0,        0);

    // Reset during ACCESS of a store: no ready, no array write.
    @(negedge clk);
    m.d_valid = 1'b1; m.d_we = 1'b1; m.d_be = 4'hF; m.d_addr = 32'h40; m.d_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    chk("mid_access", 32'(m.busy), 1);
    rst = 1'b1;
    m.d_valid = 1'b0;
    #1;
    chk("mid_rst_idle", 32'(m.busy), 0);
    bad = 0;
    repeat (3) begin @(negedge clk); if (m.d_ready) bad++; end
    rst = 1'b0;
    repeat (6) begin @(negedge clk); if (m.d_ready || m.i_ready || m.busy) bad++; end
    chk("mid_no_ready", bad, 0);

    // Tie after reset: data first, then alternate, one grant per WAIT+3 cycles.
    @(negedge clk);
    push("tie0", 1, 1, 32'h11BB33DD);
    push("tie1", 0, 1, 32'hDEADBEEF);
    push("tie2", 1, 1, 32'h11BB33DD);
    push("tie3", 0, 1, 32'hDEADBEEF);
    m.d_we = 1'b0; m.d_addr = 32'h20; m.d_valid = 1'b1;
    m.i_addr = 32'h10; m.i_valid = 1'b1;
    cnt = 0;
    g = 0;
    while (cnt < 4 && g < 60) begin
      @(negedge clk);
      g++;
      if (m.i_ready || m.d_ready) cnt++;
    end
    m.i_valid = 1'b0;
    m.d_valid = 1'b0;
    chk("tie_count", cnt, 4);
    chk("tie_span", g, 15);

    txn("ld40", 1, 0, 4'h0, 32'h40, 0, 32'h0);

    // WAIT=0 instance.
    @(negedge clk);
    b0.d_valid = 1'b1; b0.d_we = 1'b1; b0.d_be = 4'hF; b0.d_addr = 32'h8; b0.d_wdata = 32'hCAFEF00D;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b0.d_ready && lat < 60);
    b0.d_valid = 1'b0;
    chk("w0_st_lat", lat, 2);
    @(negedge clk);
    b0.d_we = 1'b0; b0.d_valid = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b0.d_ready && lat < 60);
    b0.d_valid = 1'b0;
    chk("w0_ld_lat", lat, 2);
    chk("w0_ld_data", b0.d_rdata, 32'hCAFEF00D);

    // WAIT=15 instance.
    @(negedge clk);
    b15.d_valid = 1'b1; b15.d_we = 1'b1; b15.d_be = 4'hF; b15.d_addr = 32'h8; b15.d_wdata = 32'h0F1E2D3C;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b15.d_ready && lat < 60);
    b15.d_valid = 1'b0;
    chk("w15_st_lat", lat, 17);
    @(negedge clk);
    b15.d_we = 1'b0; b15.d_valid = 1'b1;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!b15.d_ready && lat < 60);
    b15.d_valid = 1'b0;
    chk("w15_ld_lat", lat, 17);
    chk("w15_ld_data", b15.d_rdata, 32'h0F1E2D3C);

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
